// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end.
// Holds the FIFO entry bundle (PC + instruction word) and the default text base.
`ifndef TEXT_BEGIN
`define TEXT_BEGIN 32'h0000_0000
`endif

package fetch_pkg;

    localparam int unsigned INST_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(
        input logic [31:0] addr
    );
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t; flush wins over push and pop.
// Ports: clock, reset, flush, push/push_data, pop, head, count, full, empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    function automatic logic [PW-1:0] next_ptr(
        input logic [PW-1:0] p
    );
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: sequential instruction prefetcher in front of the text bus.
// Ports: clock/reset; bus_* read master; inst_* decode handshake; redirect/redirect_pc.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [31:0] RESET_PC        = `TEXT_BEGIN
) (
    input  logic        clock,
    input  logic        reset,
    output logic        bus_read_enable,
    output logic [31:0] bus_address,
    input  logic [31:0] bus_read_data,
    input  logic        bus_wait_req,
    input  logic        bus_valid,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned IW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = ((IW > CW) ? IW : CW) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [IW-1:0] in_flight;
    logic [IW-1:0] discard;
    logic [IW-1:0] drained;
    logic [CW-1:0] fifo_count;
    logic [SW-1:0] credits_used;
    logic          fifo_full;
    logic          fifo_empty;
    logic          accept;
    logic          stale;
    logic          push;
    logic          pop;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    // Every FIFO slot is pre-reserved at issue time, so a
    // returning non-stale word always finds room.
    assign credits_used = SW'(in_flight) + SW'(fifo_count);

    assign bus_read_enable = !reset && !redirect
        && (in_flight < IW'(MAX_OUTSTANDING))
        && (credits_used < SW'(DEPTH));

    assign bus_address = reset ? RESET_PC : fetch_pc;
    assign accept      = bus_read_enable && !bus_wait_req;
    assign stale       = (discard != '0);
    assign drained     = in_flight - IW'(bus_valid);

    assign push = bus_valid && !reset && !redirect && !stale;
    assign pop  = inst_valid && inst_ready && !redirect;

    assign push_entry = '{pc: resp_pc, inst: bus_read_data};

    assign inst_valid = !reset && !fifo_empty;
    assign inst_pc    = head.pc;
    assign inst_data  = head.inst;

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            resp_pc   <= RESET_PC;
            in_flight <= '0;
            discard   <= '0;
        end else if (redirect) begin
            // Everything still on the bus now belongs to
            // the abandoned stream and must be swallowed.
            fetch_pc  <= word_align(redirect_pc);
            resp_pc   <= word_align(redirect_pc);
            in_flight <= drained;
            discard   <= drained;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'(INST_BYTES);
            end
            if (push) begin
                resp_pc <= resp_pc + 32'(INST_BYTES);
            end
            if (bus_valid && stale) begin
                discard <= discard - 1'b1;
            end
            in_flight <= in_flight + IW'(accept) - IW'(bus_valid);
        end
    end

    push_never_full: assert property (
        @(posedge clock) disable iff (reset)
        !(push && fifo_full)
    );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed bench with a queue-based reference model.
// A latency-configurable in-order bus answers the DUT's reads.
module tb_fetch_prefetch_unit;

    localparam int          DEPTH    = 4;
    localparam int          MAXO     = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clock = 1'b0;
    logic        reset;
    logic        bus_read_enable;
    logic [31:0] bus_address;
    logic [31:0] bus_read_data;
    logic        bus_wait_req;
    logic        bus_valid;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    always #5 clock = ~clock;

    fetch_prefetch_unit #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (RESET_PC)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .bus_read_enable (bus_read_enable),
        .bus_address     (bus_address),
        .bus_read_data   (bus_read_data),
        .bus_wait_req    (bus_wait_req),
        .bus_valid       (bus_valid),
        .inst_valid      (inst_valid),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc)
    );

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } pend_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } bus_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } inst_t;

    pend_t       pend[$];
    bus_t        bq[$];
    inst_t       fq[$];
    inst_t       pops[$];
    logic [31:0] accs[$];
    logic [31:0] m_fpc;
    int          cyc;
    int          lat;
    int          n_checks;
    int          n_fail;

    logic        s_en;
    logic        s_iv;
    logic [31:0] s_addr;
    logic [31:0] s_pc;
    logic [31:0] s_data;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    function automatic logic [31:0] pop_pc(input int i);
        return (i < pops.size()) ? pops[i].pc : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] pop_data(input int i);
        return (i < pops.size()) ? pops[i].inst : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] acc_at(input int i);
        return (i < accs.size()) ? accs[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic chk(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic model_resp();
        pend_t p;
        n_checks++;
        if (pend.size() == 0) begin
            n_fail++;
            $display("FAIL bus_resp_pending: got 0 pending at cycle %0d", cyc);
        end else begin
            p = pend.pop_front();
            if (!redirect && !p.stale) begin
                fq.push_back('{p.addr, data_of(p.addr)});
            end
        end
    endtask

    // One clock: bus reacts, outputs are compared to the
    // model, model advances, then the edge is taken.
    task automatic step();
        logic exp_en;
        logic exp_iv;
        #1;
        if (reset) begin
            bus_valid     = 1'b0;
            bus_read_data = 32'hBAD0_BAD0;
            bq.delete();
        end else if (lat == 0) begin
            bus_valid     = bus_read_enable && !bus_wait_req;
            bus_read_data = bus_valid ? data_of(bus_address) : 32'hBAD0_BAD0;
        end else if (bq.size() > 0 && bq[0].due == cyc) begin
            bus_valid     = 1'b1;
            bus_read_data = data_of(bq[0].addr);
            void'(bq.pop_front());
        end else begin
            bus_valid     = 1'b0;
            bus_read_data = 32'hBAD0_BAD0;
        end
        if (!reset && bus_read_enable && !bus_wait_req) begin
            accs.push_back(bus_address);
            if (lat > 0) bq.push_back('{bus_address, cyc + lat});
        end
        #1;
        exp_en = !reset && !redirect && (pend.size() < MAXO)
                 && (pend.size() + fq.size() < DEPTH);
        exp_iv = !reset && (fq.size() > 0);
        chk("bus_read_enable", bus_read_enable, exp_en);
        chk("bus_address", bus_address, reset ? RESET_PC : m_fpc);
        chk("inst_valid", inst_valid, exp_iv);
        if (exp_iv && inst_valid) begin
            chk("inst_pc", inst_pc, fq[0].pc);
            chk("inst_data", inst_data, fq[0].inst);
        end
        s_en   = bus_read_enable;
        s_iv   = inst_valid;
        s_addr = bus_address;
        s_pc   = inst_pc;
        s_data = inst_data;
        if (!reset && !redirect && inst_valid && inst_ready) begin
            pops.push_back('{inst_pc, inst_data});
        end
        if (reset) begin
            pend.delete();
            fq.delete();
            m_fpc = RESET_PC;
        end else if (redirect) begin
            if (bus_valid) model_resp();
            foreach (pend[i]) pend[i].stale = 1'b1;
            fq.delete();
            m_fpc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (exp_iv && inst_ready) void'(fq.pop_front());
            if (exp_en && !bus_wait_req) begin
                pend.push_back('{m_fpc, 1'b0});
                m_fpc = m_fpc + 32'd4;
            end
            if (bus_valid) model_resp();
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int l);
        reset    = 1'b1;
        redirect = 1'b0;
        step();
        step();
        lat      = l;
        reset    = 1'b0;
        pops.delete();
        accs.delete();
    endtask

    initial begin
        reset         = 1'b1;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        inst_ready    = 1'b0;
        bus_wait_req  = 1'b0;
        bus_valid     = 1'b0;
        bus_read_data = 32'h0;
        lat           = 0;
        cyc           = 0;
        m_fpc         = RESET_PC;
        n_checks      = 0;
        n_fail        = 0;

        // Latency 0 streaming from reset
        do_reset(0);
        inst_ready = 1'b1;
        step();
        chk("t1_first_en", s_en, 1);
        chk("t1_first_addr", s_addr, 32'h0);
        chk("t1_first_iv", s_iv, 0);
        step();
        chk("t1_iv", s_iv, 1);
        chk("t1_pc0", s_pc, 32'h0);
        chk("t1_data0", s_data, 32'hCAFE_0000);
        step();
        chk("t1_pc1", s_pc, 32'h4);
        step();
        chk("t1_pc2", s_pc, 32'h8);
        chk("t1_addr3", s_addr, 32'hC);

        // Credit limit with decode stalled
        do_reset(2);
        inst_ready = 1'b0;
        repeat (10) step();
        chk("t2_reads", accs.size(), 4);
        chk("t2_en_stalled", s_en, 0);
        chk("t2_head_valid", s_iv, 1);
        chk("t2_head_pc", s_pc, 32'h0);
        inst_ready = 1'b1;
        repeat (8) step();
        chk("t2_resume_addr", acc_at(4), 32'h10);
        chk("t2_drain0", pop_pc(0), 32'h0);
        chk("t2_drain1", pop_pc(1), 32'h4);
        chk("t2_drain2", pop_pc(2), 32'h8);
        chk("t2_drain3", pop_pc(3), 32'hC);

        // Bus stall on the first request
        do_reset(1);
        inst_ready   = 1'b1;
        bus_wait_req = 1'b1;
        repeat (5) begin
            step();
            chk("t3_addr_held", s_addr, 32'h0);
            chk("t3_en_held", s_en, 1);
            chk("t3_no_inst", s_iv, 0);
        end
        chk("t3_no_accept", accs.size(), 0);
        bus_wait_req = 1'b0;
        step();
        step();
        step();
        chk("t3_iv", s_iv, 1);
        chk("t3_pc", s_pc, 32'h0);

        // Redirect with three reads in flight
        do_reset(3);
        inst_ready = 1'b1;
        repeat (3) step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        chk("t4_redirect_no_issue", s_en, 0);
        redirect = 1'b0;
        step();
        chk("t4_new_addr", s_addr, 32'h100);
        repeat (6) step();
        chk("t4_first_pc", pop_pc(0), 32'h100);
        chk("t4_first_data", pop_data(0), 32'hCAFE_0100);

        // Redirect colliding with response and pop
        do_reset(2);
        inst_ready = 1'b0;
        repeat (4) step();
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        chk("t5_had_entries", s_iv, 1);
        redirect = 1'b0;
        step();
        chk("t5_flushed", s_iv, 0);
        chk("t5_new_addr", s_addr, 32'h200);
        repeat (5) step();
        chk("t5_first_pc", pop_pc(0), 32'h200);
        chk("t5_first_data", pop_data(0), 32'hCAFE_0200);

        // Address wrap, then reset mid-stream
        do_reset(0);
        inst_ready = 1'b1;
        repeat (2) step();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect = 1'b0;
        step();
        chk("t6_top_addr", s_addr, 32'hFFFF_FFFC);
        step();
        chk("t6_wrap_addr", s_addr, 32'h0);
        chk("t6_top_pc", s_pc, 32'hFFFF_FFFC);
        step();
        chk("t6_wrap_pc", s_pc, 32'h0);
        reset = 1'b1;
        step();
        chk("t6_rst_en", s_en, 0);
        chk("t6_rst_iv", s_iv, 0);
        chk("t6_rst_addr", s_addr, RESET_PC);
        step();
        chk("t6_rst2_en", s_en, 0);
        chk("t6_rst2_iv", s_iv, 0);
        reset = 1'b0;
        pops.delete();
        accs.delete();
        step();
        chk("t6_rel_iv", s_iv, 0);
        step();
        step();
        chk("t6_refetch_addr", acc_at(0), RESET_PC);
        chk("t6_refetch_pc", pop_pc(0), RESET_PC);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
